// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command queue: opcodes, sequencer states and the
// packed command-record layout used to carry a command through the FIFO.
package gpu_pkg;

  localparam logic OP_DRAW  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned OFS_W   = 16;
  localparam int unsigned COLOR_W = 16;

  // Fixed-width fields sit at the bottom of the record, geometry above them.
  localparam int unsigned OFF_OP    = 0;
  localparam int unsigned OFF_ADDR  = 1;
  localparam int unsigned OFF_AX    = OFF_ADDR + ADDR_W;
  localparam int unsigned OFF_AY    = OFF_AX + OFS_W;
  localparam int unsigned OFF_IW    = OFF_AY + OFS_W;
  localparam int unsigned OFF_COLOR = OFF_IW + OFS_W;
  localparam int unsigned OFF_GEOM  = OFF_COLOR + COLOR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StFire, StWait} gpu_state_e;

  function automatic int unsigned coord_w(input int unsigned fb_dim);
    return $clog2(fb_dim) + 2;
  endfunction

  function automatic int unsigned rec_w(input int unsigned xw, input int unsigned yw);
    return OFF_GEOM + 2 * xw + 2 * yw;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO with combinational head data; pushes when full and pops when empty
// are ignored. Depth must be a power of two.
module gpu_cmd_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [DataWidth-1:0]   i_data,
  input  logic                   i_pop,
  output logic [DataWidth-1:0]   o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_level
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullLevel = (AW + 1)'(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_level;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_level == FullLevel);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Command FIFO and sequencer feeding the GPU draw engine: replays queued draw/clear
// commands with stable ctrl_* fields and one-cycle strobes. Define
// GPU_CMD_QUEUE_STATS_EN to add draw/clear/dropped counters.
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = 400,
  parameter int unsigned FB_HEIGHT = 240,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_op,
  input  logic [31:0]                    cmd_address,
  input  logic [15:0]                    cmd_address_x,
  input  logic [15:0]                    cmd_address_y,
  input  logic [15:0]                    cmd_image_width,
  input  logic [$clog2(FB_WIDTH)+1:0]    cmd_width,
  input  logic [$clog2(FB_HEIGHT)+1:0]   cmd_height,
  input  logic [$clog2(FB_WIDTH)+1:0]    cmd_x,
  input  logic [$clog2(FB_HEIGHT)+1:0]   cmd_y,
  input  logic [15:0]                    cmd_clear_color,
  output logic [$clog2(DEPTH):0]         queue_level,
  output logic                           queue_idle,
  output logic [31:0]                    ctrl_address,
  output logic [15:0]                    ctrl_address_x,
  output logic [15:0]                    ctrl_address_y,
  output logic [15:0]                    ctrl_image_width,
  output logic [$clog2(FB_WIDTH)+1:0]    ctrl_width,
  output logic [$clog2(FB_HEIGHT)+1:0]   ctrl_height,
  output logic [$clog2(FB_WIDTH)+1:0]    ctrl_x,
  output logic [$clog2(FB_HEIGHT)+1:0]   ctrl_y,
  output logic [15:0]                    ctrl_clear_color,
  output logic                           ctrl_draw,
  output logic                           ctrl_clear,
  input  logic                           gpu_busy
`ifdef GPU_CMD_QUEUE_STATS_EN
  ,
  output logic [31:0]                    stat_draws,
  output logic [31:0]                    stat_clears,
  output logic [31:0]                    stat_dropped
`endif
);

  localparam int unsigned XW   = coord_w(FB_WIDTH);
  localparam int unsigned YW   = coord_w(FB_HEIGHT);
  localparam int unsigned RecW = rec_w(XW, YW);
  localparam int unsigned OffW = OFF_GEOM;
  localparam int unsigned OffH = OffW + XW;
  localparam int unsigned OffX = OffH + YW;
  localparam int unsigned OffY = OffX + XW;

  logic [RecW-1:0] w_push_rec;
  logic [RecW-1:0] w_head;
  logic [RecW-1:0] r_rec;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_load;
  logic            w_discard;
  logic            w_draw_next;
  logic            w_clear_next;
  logic            r_draw;
  logic            r_clear;
  gpu_state_e      r_state;
  gpu_state_e      w_state_next;

  assign w_push_rec = {cmd_y, cmd_x, cmd_height, cmd_width, cmd_clear_color, cmd_image_width,
                       cmd_address_y, cmd_address_x, cmd_address, cmd_op};

  gpu_cmd_fifo #(
    .DataWidth(RecW),
    .Depth    (DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_push (cmd_valid),
    .i_data (w_push_rec),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(queue_level)
  );

  assign cmd_ready  = !w_full;
  assign queue_idle = w_empty && (r_state == StIdle) && !gpu_busy;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_discard    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty && !gpu_busy) begin
          w_pop = 1'b1;
          // Zero-area draws would hang nothing useful on the GPU; drop them here.
          if (w_head[OFF_OP] == OP_DRAW &&
              (w_head[OffW +: XW] == '0 || w_head[OffH +: YW] == '0)) begin
            w_discard = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_state_next = StLoad;
          end
        end
      end
      StLoad:  w_state_next = StFire;
      StFire:  w_state_next = StWait;
      StWait:  if (!gpu_busy) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_draw_next  = (r_state == StLoad) && (r_rec[OFF_OP] == OP_DRAW);
  assign w_clear_next = (r_state == StLoad) && (r_rec[OFF_OP] == OP_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_rec   <= '0;
      r_draw  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) r_rec <= w_head;
      r_draw  <= w_draw_next;
      r_clear <= w_clear_next;
    end
  end

  assign ctrl_address     = r_rec[OFF_ADDR +: ADDR_W];
  assign ctrl_address_x   = r_rec[OFF_AX +: OFS_W];
  assign ctrl_address_y   = r_rec[OFF_AY +: OFS_W];
  assign ctrl_image_width = r_rec[OFF_IW +: OFS_W];
  assign ctrl_clear_color = r_rec[OFF_COLOR +: COLOR_W];
  assign ctrl_width       = r_rec[OffW +: XW];
  assign ctrl_height      = r_rec[OffH +: YW];
  assign ctrl_x           = r_rec[OffX +: XW];
  assign ctrl_y           = r_rec[OffY +: YW];
  assign ctrl_draw        = r_draw;
  assign ctrl_clear       = r_clear;

`ifdef GPU_CMD_QUEUE_STATS_EN
  logic [31:0] r_stat_draws;
  logic [31:0] r_stat_clears;
  logic [31:0] r_stat_dropped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_draws   <= '0;
      r_stat_clears  <= '0;
      r_stat_dropped <= '0;
    end else begin
      if (r_state == StFire && r_rec[OFF_OP] == OP_DRAW)  r_stat_draws  <= r_stat_draws + 32'd1;
      if (r_state == StFire && r_rec[OFF_OP] == OP_CLEAR) r_stat_clears <= r_stat_clears + 32'd1;
      if (w_discard) r_stat_dropped <= r_stat_dropped + 32'd1;
    end
  end

  assign stat_draws   = r_stat_draws;
  assign stat_clears  = r_stat_clears;
  assign stat_dropped = r_stat_dropped;
`endif

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Scoreboard bench for gpu_cmd_queue: directed commands push expected strobes into a
// queue, a negedge monitor pops and compares on every draw/clear strobe.
module tb_gpu_cmd_queue;

  localparam int unsigned FBW   = 400;
  localparam int unsigned FBH   = 240;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned XW    = 11;
  localparam int unsigned YW    = 10;

  typedef struct packed {
    logic          op;
    logic [31:0]   addr;
    logic [15:0]   ax;
    logic [15:0]   ay;
    logic [15:0]   iw;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   color;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [31:0]   cmd_address;
  logic [15:0]   cmd_address_x;
  logic [15:0]   cmd_address_y;
  logic [15:0]   cmd_image_width;
  logic [XW-1:0] cmd_width;
  logic [YW-1:0] cmd_height;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [15:0]   cmd_clear_color;
  logic [4:0]    queue_level;
  logic          queue_idle;
  logic [31:0]   ctrl_address;
  logic [15:0]   ctrl_address_x;
  logic [15:0]   ctrl_address_y;
  logic [15:0]   ctrl_image_width;
  logic [XW-1:0] ctrl_width;
  logic [YW-1:0] ctrl_height;
  logic [XW-1:0] ctrl_x;
  logic [YW-1:0] ctrl_y;
  logic [15:0]   ctrl_clear_color;
  logic          ctrl_draw;
  logic          ctrl_clear;
  logic          gpu_busy;
`ifdef GPU_CMD_QUEUE_STATS_EN
  logic [31:0]   stat_draws;
  logic [31:0]   stat_clears;
  logic [31:0]   stat_dropped;
`endif

  gpu_cmd_queue #(
    .FB_WIDTH (FBW),
    .FB_HEIGHT(FBH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_address     (cmd_address),
    .cmd_address_x   (cmd_address_x),
    .cmd_address_y   (cmd_address_y),
    .cmd_image_width (cmd_image_width),
    .cmd_width       (cmd_width),
    .cmd_height      (cmd_height),
    .cmd_x           (cmd_x),
    .cmd_y           (cmd_y),
    .cmd_clear_color (cmd_clear_color),
    .queue_level     (queue_level),
    .queue_idle      (queue_idle),
    .ctrl_address    (ctrl_address),
    .ctrl_address_x  (ctrl_address_x),
    .ctrl_address_y  (ctrl_address_y),
    .ctrl_image_width(ctrl_image_width),
    .ctrl_width      (ctrl_width),
    .ctrl_height     (ctrl_height),
    .ctrl_x          (ctrl_x),
    .ctrl_y          (ctrl_y),
    .ctrl_clear_color(ctrl_clear_color),
    .ctrl_draw       (ctrl_draw),
    .ctrl_clear      (ctrl_clear),
    .gpu_busy        (gpu_busy)
`ifdef GPU_CMD_QUEUE_STATS_EN
    ,
    .stat_draws      (stat_draws),
    .stat_clears     (stat_clears),
    .stat_dropped    (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_strobes = 0;
  int   last_strobe_cyc = 0;
  int   fall_cyc = 0;
  int   strobe_gap = 0;
  cmd_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // GPU model: busy for busy_len cycles after each strobe, or forced by gpu_hold.
  int   busy_len = 4;
  int   busy_cnt;
  logic gpu_hold = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset)                        busy_cnt <= 0;
    else if (ctrl_draw || ctrl_clear) busy_cnt <= busy_len;
    else if (busy_cnt > 0)            busy_cnt <= busy_cnt - 1;
  end

  assign gpu_busy = gpu_hold || (busy_cnt != 0);

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t dut_view();
    cmd_t v;
    v.op    = ctrl_clear;
    v.addr  = ctrl_address;
    v.ax    = ctrl_address_x;
    v.ay    = ctrl_address_y;
    v.iw    = ctrl_image_width;
    v.w     = ctrl_width;
    v.h     = ctrl_height;
    v.x     = ctrl_x;
    v.y     = ctrl_y;
    v.color = ctrl_clear_color;
    return v;
  endfunction

  function automatic cmd_t mk(input logic op, input logic [31:0] addr, input logic [XW-1:0] w,
                              input logic [YW-1:0] h, input logic [XW-1:0] x,
                              input logic [YW-1:0] y, input logic [15:0] color);
    cmd_t c;
    c.op    = op;
    c.addr  = addr;
    c.ax    = 16'(addr[7:0]);
    c.ay    = 16'(addr[15:8]);
    c.iw    = 16'd320;
    c.w     = w;
    c.h     = h;
    c.x     = x;
    c.y     = y;
    c.color = color;
    return c;
  endfunction

  // Offers one command for one edge; exp_issue says whether a strobe must follow.
  task automatic push(input cmd_t c, input logic exp_acc, input logic exp_issue);
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_op          = c.op;
    cmd_address     = c.addr;
    cmd_address_x   = c.ax;
    cmd_address_y   = c.ay;
    cmd_image_width = c.iw;
    cmd_width       = c.w;
    cmd_height      = c.h;
    cmd_x           = c.x;
    cmd_y           = c.y;
    cmd_clear_color = c.color;
    check("cmd_ready", cmd_ready, exp_acc);
    if (exp_acc && exp_issue) sb.push_back(c);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int max_cyc);
    int i = 0;
    while (n_strobes < target && i < max_cyc) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("strobe_count", n_strobes, target);
  endtask

  task automatic wait_idle(input int max_cyc);
    int i = 0;
    @(negedge clk);
    #1;
    while (!(queue_idle && sb.size() == 0) && i < max_cyc) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("queue_idle", queue_idle, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  // Monitor: scoreboard compare on each strobe, strobe spacing, field stability while busy.
  initial begin
    logic prev_strobe = 1'b0;
    logic prev_busy   = 1'b0;
    logic unstable    = 1'b0;
    logic have_latch  = 1'b0;
    cmd_t latch, cur, e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_strobe = 1'b0;
        prev_busy   = gpu_busy;
        unstable    = 1'b0;
        have_latch  = 1'b0;
      end else begin
        if (ctrl_draw || ctrl_clear) begin
          n_strobes++;
          last_strobe_cyc = cyc;
          strobe_gap      = cyc - fall_cyc;
          check("strobe_not_back_to_back", prev_strobe, 0);
          check("strobe_one_hot", ctrl_draw && ctrl_clear, 0);
          check("strobe_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("strobe_cmd", dut_view(), e);
          end
          latch      = dut_view();
          latch.op   = 1'b0;
          have_latch = 1'b1;
        end
        if (gpu_busy && have_latch) begin
          cur    = dut_view();
          cur.op = 1'b0;
          if (cur != latch) unstable = 1'b1;
        end
        if (prev_busy && !gpu_busy) begin
          fall_cyc = cyc;
          if (have_latch) check("fields_stable", unstable, 0);
          unstable = 1'b0;
        end
        prev_strobe = ctrl_draw || ctrl_clear;
        prev_busy   = gpu_busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int base;
    cmd_valid = 1'b0;
    cmd_op = 1'b0; cmd_address = '0; cmd_address_x = '0; cmd_address_y = '0;
    cmd_image_width = '0; cmd_width = '0; cmd_height = '0; cmd_x = '0; cmd_y = '0;
    cmd_clear_color = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_level", queue_level, 0);
    check("rst_idle", queue_idle, 1);
    check("rst_strobes", {ctrl_draw, ctrl_clear}, 0);
    check("rst_ctrl", dut_view(), 0);
    reset = 1'b0;

    // Single draw, 256-cycle busy: strobe two edges after the push edge.
    busy_len = 256;
    push(mk(1'b0, 32'h1000, 11'd16, 10'd16, 11'd8, 10'd8, 16'h0), 1'b1, 1'b1);
    p = cyc;
    check("t1_level_after_push", queue_level, 1);
    check("t1_not_idle", queue_idle, 0);
    wait_strobes(1, 20);
    check("t1_latency", last_strobe_cyc, p + 2);
    wait_idle(400);

    // Clear (zero geometry is fine for clears) then draw back-to-back.
    busy_len = 10;
    base = n_strobes;
    push(mk(1'b1, 32'h0, 11'd0, 10'd0, 11'd0, 10'd0, 16'hFFFF), 1'b1, 1'b1);
    push(mk(1'b0, 32'h2000, 11'd32, 10'd8, 11'd100, 10'd50, 16'h0), 1'b1, 1'b1);
    wait_strobes(base + 2, 100);
    check("t2_gap_after_busy_fall", strobe_gap, 3);
    wait_idle(100);

    // Fill with GPU held busy; DEPTH+1-th offer must be refused.
    busy_len = 3;
    gpu_hold = 1'b1;
    base = n_strobes;
    for (int i = 0; i < 16; i++) begin
      push(mk(i[0], 32'(32'h3000 + i * 16), 11'(i + 1), 10'(i + 2), 11'(i), 10'(i), 16'(i)),
           1'b1, 1'b1);
    end
    push(mk(1'b0, 32'h3F00, 11'd5, 10'd5, 11'd1, 10'd1, 16'h0), 1'b0, 1'b0);
    check("t3_level_full", queue_level, DEPTH);
    check("t3_ready_low", cmd_ready, 0);
    gpu_hold = 1'b0;
    wait_strobes(base + 16, 300);
    wait_idle(100);
    check("t3_no_extra_strobe", n_strobes, base + 16);

    // Zero-width draw is discarded; the following 4x4 draw is issued.
    busy_len = 5;
    base = n_strobes;
    push(mk(1'b0, 32'h4000, 11'd0, 10'd4, 11'd2, 10'd2, 16'h0), 1'b1, 1'b0);
    push(mk(1'b0, 32'h4100, 11'd4, 10'd4, 11'd3, 10'd3, 16'h0), 1'b1, 1'b1);
    wait_strobes(base + 1, 50);
    wait_idle(50);
    check("t4_single_strobe", n_strobes, base + 1);
`ifdef GPU_CMD_QUEUE_STATS_EN
    check("t4_stat_dropped", stat_dropped, 1);
`endif

    // Reset during WAIT with three commands still queued.
    busy_len = 40;
    base = n_strobes;
    for (int i = 0; i < 4; i++) begin
      push(mk(1'b0, 32'(32'h6000 + i * 4), 11'd8, 10'd8, 11'd0, 10'd0, 16'h0), 1'b1, 1'b1);
    end
    wait_strobes(base + 1, 20);
    repeat (5) @(negedge clk);
    #1;
    check("t5_level_before_reset", queue_level, 3);
    reset = 1'b1;
    #1;
    check("t5_rst_ctrl", dut_view(), 0);
    check("t5_rst_strobes", {ctrl_draw, ctrl_clear}, 0);
    check("t5_rst_level", queue_level, 0);
    check("t5_rst_ready", cmd_ready, 1);
    sb.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("t5_no_strobe_after_reset", n_strobes, base + 1);
    check("t5_idle_after_reset", queue_idle, 1);

    // Five draws and two clears.
    busy_len = 3;
    base = n_strobes;
    for (int i = 0; i < 7; i++) begin
      push(mk((i == 2 || i == 5), 32'(32'h5000 + i * 4), 11'd8, 10'd4, 11'(i * 3), 10'(i),
              16'h1234), 1'b1, 1'b1);
    end
    wait_strobes(base + 7, 150);
    wait_idle(50);
`ifdef GPU_CMD_QUEUE_STATS_EN
    check("t6_stat_draws", stat_draws, 5);
    check("t6_stat_clears", stat_clears, 2);
    check("t6_stat_dropped", stat_dropped, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
